// File: rtl/banked_tcdm_ram_pkg.sv
// banked_tcdm_ram_pkg: clear FSM states and sizing/round-robin helpers for the banked TCDM RAM
package banked_tcdm_ram_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
  function automatic int bsel_w(input int num_banks);
    return $clog2(num_banks);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int rr(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction
endpackage

// File: rtl/tcdm_ram_bank.sv
// tcdm_ram_bank: single-port byte-enabled bank, read-first registered read, out-of-range rows read 0 and ignore writes
module tcdm_ram_bank #(
  parameter int ROWS = 512,
  parameter int ROW_W = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ROW_W-1:0]        row,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int IDX_W = ROWS > 1 ? $clog2(ROWS) : 1;
  logic [DATA_WIDTH-1:0] mem [ROWS];
  logic                  ok;
  logic [IDX_W-1:0]      idx;
  assign ok = {1'b0, row} < (ROW_W + 1)'(ROWS);
  assign idx = IDX_W'(row);
  always_ff @(posedge clk)
    if (en) begin
      rdata <= ok ? mem[idx] : '0;
      for (int i = 0; i < DATA_WIDTH / 8; i++)
        if (we && ok && be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
endmodule

// File: rtl/banked_tcdm_ram.sv
// banked_tcdm_ram: multi-port word-interleaved banked RAM with per-bank round-robin arbitration (BANKED_TCDM_RAM_CLEAR_EN adds a zero-clear FSM after reset)
module banked_tcdm_ram
  import banked_tcdm_ram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_BANKS = 2,
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o,
  output logic                              init_done_o
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam int BSEL = bsel_w(NUM_BANKS);
  localparam int ROWS = NUM_WORDS / NUM_BANKS;
  localparam int ROW_W = ADDR_WIDTH - BSEL;
  localparam int PW = idx_w(NUM_PORTS);
  localparam int BW = idx_w(NUM_BANKS);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
  } port_req_t;
  port_req_t             pr [NUM_PORTS];
  logic [BW-1:0]         pbank [NUM_PORTS];
  logic [ROW_W-1:0]      prow [NUM_PORTS];
  logic [PW-1:0]         ptr_q [NUM_BANKS];
  logic [PW-1:0]         win [NUM_BANKS];
  logic [PW-1:0]         cand;
  logic [NUM_BANKS-1:0]  hit;
  logic [DATA_WIDTH-1:0] brdata [NUM_BANKS];
  logic [BW-1:0]         rbank_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] hold_q [NUM_PORTS];
  logic                  clearing;
  logic [ROW_W-1:0]      crow;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign pr[p] = '{addr: addr_i[p*ADDR_WIDTH +: ADDR_WIDTH], we: we_i[p],
                     be: be_i[p*BE_W +: BE_W], wdata: wdata_i[p*DATA_WIDTH +: DATA_WIDTH]};
    assign pbank[p] = BW'(pr[p].addr & ADDR_WIDTH'(NUM_BANKS - 1));
    assign prow[p] = ROW_W'(pr[p].addr >> BSEL);
  end
`ifdef BANKED_TCDM_RAM_CLEAR_EN
  clr_state_e       state_q;
  logic [ROW_W-1:0] crow_q;
  logic             done_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= CLEAR;
      crow_q <= '0;
      done_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      crow_q <= crow_q + 1'b1;
      if (crow_q == ROW_W'(ROWS - 1)) begin
        state_q <= DONE;
        done_q <= 1'b1;
      end
    end
  assign clearing = state_q == CLEAR;
  assign crow = crow_q;
  assign init_done_o = done_q;
`else
  assign clearing = 1'b0;
  assign crow = '0;
  assign init_done_o = !rst;
`endif
  always_comb begin
    gnt_o = '0;
    hit = '0;
    cand = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      win[b] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = PW'(rr(int'(ptr_q[b]), k, NUM_PORTS));
        if (!hit[b] && init_done_o && req_i[cand] && pbank[cand] == BW'(b)) begin
          hit[b] = 1'b1;
          win[b] = cand;
        end
      end
      if (hit[b]) gnt_o[win[b]] = 1'b1;
    end
  end
  always_ff @(posedge clk)
    for (int b = 0; b < NUM_BANKS; b++)
      ptr_q[b] <= rst ? '0 : hit[b] ? PW'(rr(int'(win[b]), 1, NUM_PORTS)) : ptr_q[b];
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    tcdm_ram_bank #(.ROWS(ROWS), .ROW_W(ROW_W), .DATA_WIDTH(DATA_WIDTH)) u_bank (
      .clk   (clk),
      .en    (!rst && (clearing || hit[b])),
      .we    (clearing || pr[win[b]].we),
      .be    (clearing ? '1 : pr[win[b]].be),
      .row   (clearing ? crow : prow[win[b]]),
      .wdata (clearing ? '0 : pr[win[b]].wdata),
      .rdata (brdata[b])
    );
  end
  always_ff @(posedge clk) begin
    rvalid_o <= rst ? '0 : gnt_o;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rbank_q[p] <= pbank[p];
      if (rst) hold_q[p] <= '0;
      else if (rvalid_o[p]) hold_q[p] <= rdata_o[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rvalid_o[p] ? brdata[rbank_q[p]] : hold_q[p];
  end
endmodule

// File: tb/tb_banked_tcdm_ram.sv
// tb_banked_tcdm_ram: directed scoreboard bench for banked_tcdm_ram
module tb_banked_tcdm_ram;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt, we, rvalid;
  logic [19:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata, rdata;
  logic        init_done;
  logic [1:0]  req2, gnt2, we2, rvalid2;
  logic [19:0] addr2;
  logic [7:0]  be2;
  logic [63:0] wdata2, rdata2;
  logic        init_done2;
  typedef struct {
    logic        care;
    logic [31:0] data;
  } exp_t;
  exp_t        sbq [2][$];
  logic [31:0] hold [2];
  logic        hold_known [2];
  logic        mon_en = 1'b0;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  banked_tcdm_ram dut (
    .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .init_done_o(init_done)
  );
  banked_tcdm_ram #(.NUM_WORDS(768)) dut768 (
    .clk(clk), .rst(rst), .req_i(req2), .gnt_o(gnt2), .addr_i(addr2), .we_i(we2), .be_i(be2),
    .wdata_i(wdata2), .rvalid_o(rvalid2), .rdata_o(rdata2), .init_done_o(init_done2)
  );
  task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s port%0d: got %h expected %h", name, p, act, exp);
    end
  endtask
  task automatic mon_port(input int p);
    exp_t e;
    logic has;
    has = sbq[p].size() != 0;
    chk("rvalid", p, 32'(rvalid[p]), 32'(has));
    e = '{1'b0, 32'h0};
    if (has) e = sbq[p].pop_front();
    if (rvalid[p] && has) begin
      hold_known[p] = e.care;
      hold[p] = e.data;
      if (e.care) chk("rdata", p, rdata[p*32 +: 32], e.data);
    end else if (!rvalid[p] && hold_known[p]) chk("rdata_hold", p, rdata[p*32 +: 32], hold[p]);
  endtask
  always @(negedge clk)
    if (mon_en) begin
      mon_port(0);
      mon_port(1);
    end
  task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] w,
                      input logic [9:0] a0, input logic [9:0] a1,
                      input logic [3:0] b0, input logic [3:0] b1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] eg, input logic [1:0] ec,
                      input logic [31:0] e0, input logic [31:0] e1);
    @(negedge clk);
    rst = r;
    req = rq;
    we = w;
    addr = {a1, a0};
    be = {b1, b0};
    wdata = {d1, d0};
    #1;
    if (r) begin
      hold[0] = '0;
      hold[1] = '0;
      hold_known[0] = 1'b1;
      hold_known[1] = 1'b1;
    end
    chk("gnt", 0, 32'(gnt), 32'(eg));
    if (eg[0]) sbq[0].push_back('{ec[0], e0});
    if (eg[1]) sbq[1].push_back('{ec[1], e1});
  endtask
  task automatic step2(input logic w, input logic [9:0] a, input logic [31:0] d,
                       input logic c, input logic [31:0] e);
    @(negedge clk);
    req2 = 2'b01;
    we2 = {1'b0, w};
    addr2 = {10'h0, a};
    be2 = 8'h0F;
    wdata2 = {32'h0, d};
    #1;
    chk("gnt768", 0, 32'(gnt2), 32'h1);
    @(negedge clk);
    req2 = '0;
    chk("rvalid768", 0, 32'(rvalid2), 32'h1);
    if (c) chk("rdata768", 0, rdata2[31:0], e);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    req = '0; we = '0; addr = '0; be = '0; wdata = '0;
    req2 = '0; we2 = '0; addr2 = '0; be2 = '0; wdata2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", 0, 32'(gnt), 32'h0);
    chk("reset_rvalid", 0, 32'(rvalid), 32'h0);
    chk("reset_rdata0", 0, rdata[31:0], 32'h0);
    chk("reset_rdata1", 1, rdata[63:32], 32'h0);
    chk("reset_init_done", 0, 32'(init_done), 32'h0);
    hold[0] = '0; hold[1] = '0;
    hold_known[0] = 1'b1; hold_known[1] = 1'b1;
    mon_en = 1'b1;
    step(0, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("init_done", 0, 32'(init_done), 32'h1);
    step(0, 2'b01, 2'b01, 10'h004, 10'h000, 4'hF, 4'h0, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0);
    step(0, 2'b01, 2'b01, 10'h004, 10'h000, 4'b0101, 4'h0, 32'hDEADBEEF, 32'h0, 2'b01, 2'b01, 32'h0, 32'h0);
    step(0, 2'b01, 2'b00, 10'h004, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 32'h00AD00EF, 32'h0);
    step(0, 2'b01, 2'b01, 10'h004, 10'h000, 4'h0, 4'h0, 32'hFFFFFFFF, 32'h0, 2'b01, 2'b01, 32'h00AD00EF, 32'h0);
    step(0, 2'b01, 2'b00, 10'h004, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 32'h00AD00EF, 32'h0);
    step(0, 2'b10, 2'b10, 10'h000, 10'h010, 4'h0, 4'hF, 32'h0, 32'h11111111, 2'b10, 2'b00, 32'h0, 32'h0);
    step(0, 2'b10, 2'b10, 10'h000, 10'h020, 4'h0, 4'hF, 32'h0, 32'h22222222, 2'b10, 2'b00, 32'h0, 32'h0);
    step(0, 2'b10, 2'b10, 10'h000, 10'h011, 4'h0, 4'hF, 32'h0, 32'h33333333, 2'b10, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++)
      step(0, 2'b11, 2'b00, 10'h010, 10'h020, 4'h0, 4'h0, 32'h0, 32'h0,
           i[0] ? 2'b10 : 2'b01, 2'b11, 32'h11111111, 32'h22222222);
    for (int i = 0; i < 2; i++)
      step(0, 2'b11, 2'b00, 10'h010, 10'h011, 4'h0, 4'h0, 32'h0, 32'h0, 2'b11, 2'b11, 32'h11111111, 32'h33333333);
    step(0, 2'b11, 2'b11, 10'h008, 10'h009, 4'hF, 4'hF, 32'hA5A5A5A5, 32'h99999999, 2'b11, 2'b00, 32'h0, 32'h0);
    step(0, 2'b11, 2'b01, 10'h008, 10'h009, 4'hF, 4'h0, 32'h00000055, 32'h0, 2'b11, 2'b11, 32'hA5A5A5A5, 32'h99999999);
    step(0, 2'b10, 2'b00, 10'h000, 10'h008, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b10, 32'h0, 32'h00000055);
    step(0, 2'b01, 2'b00, 10'h008, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b01, 32'h00000055, 32'h0);
    step(0, 2'b11, 2'b00, 10'h010, 10'h011, 4'h0, 4'h0, 32'h0, 32'h0, 2'b11, 2'b11, 32'h11111111, 32'h33333333);
    step(1, 2'b11, 2'b11, 10'h010, 10'h011, 4'hF, 4'hF, 32'h00000BAD, 32'h00000BAD, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("rst_init_done", 0, 32'(init_done), 32'h0);
    step(0, 2'b11, 2'b00, 10'h010, 10'h020, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 2'b11, 32'h11111111, 32'h22222222);
    step(0, 2'b11, 2'b00, 10'h010, 10'h020, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b11, 32'h11111111, 32'h22222222);
    step(0, 2'b10, 2'b00, 10'h000, 10'h011, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 2'b10, 32'h0, 32'h33333333);
    step(0, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    step(0, 2'b00, 2'b00, 10'h000, 10'h000, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    chk("drain", 0, 32'(sbq[0].size()), 32'h0);
    chk("drain", 1, 32'(sbq[1].size()), 32'h0);
    step2(1'b1, 10'h0FE, 32'h0, 1'b0, 32'h0);
    step2(1'b1, 10'h1FE, 32'h0, 1'b0, 32'h0);
    step2(1'b1, 10'h2FE, 32'h12345678, 1'b0, 32'h0);
    step2(1'b1, 10'h3FE, 32'hFFFFFFFF, 1'b1, 32'h0);
    step2(1'b0, 10'h3FE, 32'h0, 1'b1, 32'h0);
    step2(1'b0, 10'h0FE, 32'h0, 1'b1, 32'h0);
    step2(1'b0, 10'h1FE, 32'h0, 1'b1, 32'h0);
    step2(1'b0, 10'h2FE, 32'h0, 1'b1, 32'h12345678);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
